// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 5-byte command frames (A5, OP, ARG_HI, ARG_LO, CHK)
// from the UART receiver and drives the ADC configuration registers.
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout abort).
module uart_cmd_ctrl #(
  parameter logic [15:0] DIV_RESET      = 16'd1000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  RxData,
  input  logic        RxReady,
  input  logic        RxError,
  output logic [15:0] Divider,
  output logic [2:0]  Channel,
  output logic        CaptureEn,
  output logic        CmdStrobe,
  output logic [7:0]  CmdOpcode,
  output logic        FrameErr,
  output logic [7:0]  ErrCount
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC, S_OPCODE, S_ARG_HI, S_ARG_LO, S_CHECK, S_EXEC
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_q, err_q;
  logic [7:0]  op_q, op_d, ahi_q, ahi_d, alo_q, alo_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  ch_q, ch_d;
  logic        cap_q, cap_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        ferr_q;
  logic [7:0]  errcnt_q, errcnt_d;
  logic        byte_ev_c, err_ev_c, abort_c, timeout_c;

  assign byte_ev_c = RxReady & ~rdy_q;
  assign err_ev_c  = RxError & ~err_q;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] tmo_q;

  // Idle counter: cleared by each byte and while waiting for a sync byte
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_q <= 24'd0;
    end else if (state_q == S_SYNC || byte_ev_c) begin
      tmo_q <= 24'd0;
    end else if (tmo_q != TIMEOUT_CYCLES) begin
      tmo_q <= tmo_q + 24'd1;
    end
  end

  assign timeout_c = (state_q != S_SYNC) && (tmo_q == TIMEOUT_CYCLES);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout_c  = 1'b0;
`endif

  // Frame parser next state, config updates and abort detection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ahi_d    = ahi_q;
    alo_d    = alo_q;
    div_d    = div_q;
    ch_d     = ch_q;
    cap_d    = cap_q;
    strobe_d = 1'b0;
    opcode_d = opcode_q;
    abort_c  = 1'b0;
    if (err_ev_c && state_q != S_SYNC) begin
      abort_c = 1'b1;
    end else if (timeout_c) begin
      abort_c = 1'b1;
    end else begin
      case (state_q)
        S_SYNC:   if (byte_ev_c && RxData == SYNC_BYTE) state_d = S_OPCODE;
        S_OPCODE: if (byte_ev_c) begin op_d  = RxData; state_d = S_ARG_HI; end
        S_ARG_HI: if (byte_ev_c) begin ahi_d = RxData; state_d = S_ARG_LO; end
        S_ARG_LO: if (byte_ev_c) begin alo_d = RxData; state_d = S_CHECK;  end
        S_CHECK: begin
          if (byte_ev_c) begin
            if (RxData == (op_q ^ ahi_q ^ alo_q)) state_d = S_EXEC;
            else                                  abort_c = 1'b1;
          end
        end
        S_EXEC: begin
          state_d  = S_SYNC;
          strobe_d = 1'b1;
          opcode_d = op_q;
          case (op_q)
            8'h01:   div_d = ({ahi_q, alo_q} == 16'd0) ? 16'd1 : {ahi_q, alo_q};
            8'h02:   ch_d  = alo_q[2:0];
            8'h03:   cap_d = alo_q[0];
            8'h04: begin
              div_d = DIV_RESET;
              ch_d  = 3'd0;
              cap_d = 1'b0;
            end
            default: begin
              strobe_d = 1'b0;
              opcode_d = opcode_q;
              abort_c  = 1'b1;
            end
          endcase
        end
        default: state_d = S_SYNC;
      endcase
    end
    if (abort_c) begin
      state_d = S_SYNC;
      div_d   = div_q;
      ch_d    = ch_q;
      cap_d   = cap_q;
    end
    errcnt_d = (abort_c && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
  end

  // State, edge detectors and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_SYNC;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      op_q     <= 8'd0;
      ahi_q    <= 8'd0;
      alo_q    <= 8'd0;
      div_q    <= DIV_RESET;
      ch_q     <= 3'd0;
      cap_q    <= 1'b0;
      strobe_q <= 1'b0;
      opcode_q <= 8'd0;
      ferr_q   <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= RxReady;
      err_q    <= RxError;
      op_q     <= op_d;
      ahi_q    <= ahi_d;
      alo_q    <= alo_d;
      div_q    <= div_d;
      ch_q     <= ch_d;
      cap_q    <= cap_d;
      strobe_q <= strobe_d;
      opcode_q <= opcode_d;
      ferr_q   <= abort_c;
      errcnt_q <= errcnt_d;
    end
  end

  assign Divider   = div_q;
  assign Channel   = ch_q;
  assign CaptureEn = cap_q;
  assign CmdStrobe = strobe_q;
  assign CmdOpcode = opcode_q;
  assign FrameErr  = ferr_q;
  assign ErrCount  = errcnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  RxData;
  logic        RxReady;
  logic        RxError;
  logic [15:0] Divider;
  logic [2:0]  Channel;
  logic        CaptureEn;
  logic        CmdStrobe;
  logic [7:0]  CmdOpcode;
  logic        FrameErr;
  logic [7:0]  ErrCount;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;
  int ferr_cnt   = 0;
  int s0, f0;

  uart_cmd_ctrl #(.DIV_RESET(16'd1000), .TIMEOUT_CYCLES(24'd50)) dut (
    .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxReady(RxReady),
    .RxError(RxError), .Divider(Divider), .Channel(Channel),
    .CaptureEn(CaptureEn), .CmdStrobe(CmdStrobe), .CmdOpcode(CmdOpcode),
    .FrameErr(FrameErr), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  // Count high cycles of the pulse outputs
  always @(posedge Clk) begin
    if (CmdStrobe === 1'b1) strobe_cnt++;
    if (FrameErr === 1'b1)  ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clk);
    RxData  = b;
    RxReady = 1'b1;
    idle(2);
    RxReady = 1'b0;
    idle(1);
  endtask

  task automatic pulse_err();
    @(negedge Clk);
    RxError = 1'b1;
    idle(2);
    RxError = 1'b0;
    idle(1);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(hi);
    send_byte(lo);
    send_byte(chk);
    idle(3);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo);
    send_frame(op, hi, lo, op ^ hi ^ lo);
  endtask

  task automatic mark();
    s0 = strobe_cnt;
    f0 = ferr_cnt;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_div"},    32'(Divider),   32'd1000);
    check({tag, "_ch"},     32'(Channel),   32'd0);
    check({tag, "_cap"},    32'(CaptureEn), 32'd0);
    check({tag, "_strobe"}, 32'(CmdStrobe), 32'd0);
    check({tag, "_opc"},    32'(CmdOpcode), 32'd0);
    check({tag, "_ferr"},   32'(FrameErr),  32'd0);
    check({tag, "_errcnt"}, 32'(ErrCount),  32'd0);
  endtask

  initial begin
    Reset = 1'b0; RxData = 8'h00; RxReady = 1'b0; RxError = 1'b0;
    idle(3);
    check_reset_vals("rst");
    Reset = 1'b1;
    idle(2);

    // Divider write: 01^12^34 = 27
    mark();
    send_cmd(8'h01, 8'h12, 8'h34);
    check("t1_div",    32'(Divider),   32'h1234);
    check("t1_strobe", strobe_cnt - s0, 32'd1);
    check("t1_opc",    32'(CmdOpcode), 32'h01);
    check("t1_errcnt", 32'(ErrCount),  32'd0);
    check("t1_ferr",   ferr_cnt - f0,  32'd0);

    // Channel and capture enable, then defaults
    mark();
    send_frame(8'h02, 8'h00, 8'h05, 8'h07);
    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    check("t2_ch",     32'(Channel),   32'd5);
    check("t2_cap",    32'(CaptureEn), 32'd1);
    check("t2_strobe", strobe_cnt - s0, 32'd2);
    check("t2_opc",    32'(CmdOpcode), 32'h03);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    check("t2_def_div", 32'(Divider),   32'd1000);
    check("t2_def_ch",  32'(Channel),   32'd0);
    check("t2_def_cap", 32'(CaptureEn), 32'd0);
    check("t2_def_opc", 32'(CmdOpcode), 32'h04);

    // Bad checksum (27 is correct), then a good frame
    mark();
    send_frame(8'h01, 8'h12, 8'h34, 8'h26);
    check("t3_ferr",   ferr_cnt - f0,  32'd1);
    check("t3_errcnt", 32'(ErrCount),  32'd1);
    check("t3_div",    32'(Divider),   32'd1000);
    check("t3_strobe", strobe_cnt - s0, 32'd0);
    send_cmd(8'h01, 8'h12, 8'h34);
    check("t3_good_div", 32'(Divider), 32'h1234);

    // Leading junk then unknown opcode
    mark();
    send_byte(8'h55);
    send_byte(8'h00);
    send_frame(8'h09, 8'h00, 8'h00, 8'h09);
    check("t4_ferr",   ferr_cnt - f0,  32'd1);
    check("t4_strobe", strobe_cnt - s0, 32'd0);
    check("t4_errcnt", 32'(ErrCount),  32'd2);
    check("t4_opc",    32'(CmdOpcode), 32'h01);
    send_frame(8'h01, 8'h00, 8'h00, 8'h01);
    check("t4_div_zero", 32'(Divider), 32'd1);

    // A5 as payload data
    send_cmd(8'h01, 8'hA5, 8'h00);
    check("t4_a5_data", 32'(Divider), 32'hA500);

    // Receiver error in SYNC is ignored; mid-frame aborts
    mark();
    pulse_err();
    check("t5_sync_err", 32'(ErrCount), 32'd2);
    send_byte(8'hA5);
    send_byte(8'h01);
    pulse_err();
    send_frame(8'h02, 8'h00, 8'h03, 8'h01);
    check("t5_ferr",   ferr_cnt - f0,  32'd1);
    check("t5_errcnt", 32'(ErrCount),  32'd3);
    check("t5_ch",     32'(Channel),   32'd3);

    // Error and byte together: byte is discarded, frame aborts
    mark();
    send_byte(8'hA5);
    @(negedge Clk);
    RxData = 8'h02; RxReady = 1'b1; RxError = 1'b1;
    idle(2);
    RxReady = 1'b0; RxError = 1'b0;
    idle(3);
    check("t6_ferr",   ferr_cnt - f0, 32'd1);
    check("t6_errcnt", 32'(ErrCount), 32'd4);
    send_cmd(8'h02, 8'h00, 8'h02);
    check("t6_ch",     32'(Channel),  32'd2);

    // Stall of 60 cycles after A5 01
    mark();
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(60);
`ifdef CMD_TIMEOUT_EN
    check("t7_tmo_ferr",   ferr_cnt - f0, 32'd1);
    check("t7_tmo_errcnt", 32'(ErrCount), 32'd5);
    send_cmd(8'h03, 8'h00, 8'h01);
    check("t7_tmo_cap",    32'(CaptureEn), 32'd1);
`else
    check("t7_wait_ferr",  ferr_cnt - f0, 32'd0);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h04);
    idle(3);
    check("t7_wait_div",   32'(Divider), 32'd5);
`endif

    // Reset mid-frame, asserted asynchronously
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    idle(2);
    Reset = 1'b1;
    idle(2);
    send_byte(8'h07);
    send_byte(8'h05);
    idle(3);
    check("midrst_sync_ch", 32'(Channel), 32'd0);
    send_cmd(8'h02, 8'h00, 8'h06);
    check("midrst_ch", 32'(Channel), 32'd6);

    // Error counter saturation
    mark();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5);
      pulse_err();
      if (i == 253) check("sat_254", 32'(ErrCount), 32'd254);
    end
    idle(2);
    check("sat_errcnt", 32'(ErrCount), 32'd255);
    check("sat_ferr",   ferr_cnt - f0, 32'd300);
    check("sat_div",    32'(Divider),  32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
